// File: rtl/alu_mdu.sv
// Execute-stage ALU with a multi-cycle signed/unsigned multiply/divide unit.
// Latency: ALU result combinational; MDU result WIDTH+1 cycles after start.
// Backpressure: start is ignored while busy; control stalls the pipe on busy.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_ctrl,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_c,
  output logic             o_zero,
  output logic             o_overflow,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [SW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_lo;   // product sign (mult) or quotient sign (div)
  logic               r_neg_hi;   // remainder sign = dividend sign
  logic [WIDTH-1:0]   r_mcand;    // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] r_prod;     // {upper, lower}: product or {remainder, quotient}
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic [SW-1:0]      w_shamt;
  logic [WIDTH-1:0]   w_sum, w_diff;
  logic               w_accept, w_last;
  logic               w_signed, w_a_neg, w_b_neg, w_b_zero;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_madd, w_dtop;
  logic [WIDTH+1:0]   w_dsub;
  logic               w_borrow;
  logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_step, w_prod_fix;
  logic [WIDTH-1:0]   w_q, w_r, w_res_hi, w_res_lo;

  assign w_shamt = i_a[SW-1:0];
  assign w_sum   = i_a + i_b;
  assign w_diff  = i_a - i_b;

  // Combinational ALU result and add/sub overflow flag
  always_comb begin
    o_c        = i_b;
    o_overflow = 1'b0;
    case (i_ctrl)
      4'b0001: begin
        o_c        = w_sum;
        o_overflow = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
      end
      4'b0010: begin
        o_c        = w_diff;
        o_overflow = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
      end
      4'b0011: o_c = i_a & i_b;
      4'b0100: o_c = i_a | i_b;
      4'b0101: o_c = i_a ^ i_b;
      4'b0110: o_c = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      4'b0111: o_c = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      4'b1000: o_c = i_b << w_shamt;
      4'b1001: o_c = i_b >> w_shamt;
      4'b1010: o_c = $signed(i_b) >>> w_shamt;
      4'b1011: o_c = {i_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: o_c = i_b;
    endcase
  end

  assign o_zero = (o_c == '0);

  // Operand magnitudes and result signs captured on acceptance
  assign w_accept = (r_state != S_RUN) && i_start && (i_ctrl[3:2] == 2'b11);
  assign w_signed = ~i_ctrl[0];
  assign w_a_neg  = w_signed && i_a[MSB];
  assign w_b_neg  = w_signed && i_b[MSB];
  assign w_b_zero = (i_b == '0);
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;

  // One shift-add multiply step: add multiplicand on LSB, shift right
  assign w_madd    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_mcand : {WIDTH{1'b0}})};
  assign w_mul_nxt = {w_madd, r_prod[WIDTH-1:1]};

  // One restoring divide step: shift left, try subtracting divisor
  assign w_dtop    = r_prod[2*WIDTH-1:WIDTH-1];
  assign w_dsub    = {1'b0, w_dtop} - {2'b00, r_mcand};
  assign w_borrow  = w_dsub[WIDTH+1];
  assign w_div_nxt = {(w_borrow ? w_dtop[WIDTH-1:0] : w_dsub[WIDTH-1:0]),
                      r_prod[WIDTH-2:0], ~w_borrow};

  assign w_step = r_is_div ? w_div_nxt : w_mul_nxt;
  assign w_last = (r_state == S_RUN) && (r_cnt == SW'(WIDTH - 1));

  // Sign correction on the final step result
  assign w_prod_fix = r_neg_lo ? -w_step : w_step;
  assign w_q        = w_step[WIDTH-1:0];
  assign w_r        = w_step[2*WIDTH-1:WIDTH];
  assign w_res_lo   = r_is_div ? (r_neg_lo ? -w_q : w_q) : w_prod_fix[WIDTH-1:0];
  assign w_res_hi   = r_is_div ? (r_neg_hi ? -w_r : w_r) : w_prod_fix[2*WIDTH-1:WIDTH];

  // MDU state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // MDU next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RUN;
      S_RUN: begin
        o_busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = w_accept ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // MDU datapath: latch operands, iterate, load HI/LO on the final step
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_is_div <= i_ctrl[1];
      // A zero divisor yields an all-ones quotient regardless of signs
      r_neg_lo <= (w_a_neg ^ w_b_neg) && !(i_ctrl[1] && w_b_zero);
      r_neg_hi <= w_a_neg;
      r_mcand  <= w_b_mag;
      r_prod   <= {{WIDTH{1'b0}}, w_a_mag};
    end else if (r_state == S_RUN) begin
      r_cnt  <= r_cnt + SW'(1);
      r_prod <= w_step;
      if (w_last) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu (WIDTH=32).
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
// Every MDU wait is bounded so the bench always reaches its summary line.
module tb_alu_mdu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] i_a, i_b;
  logic [3:0]   i_ctrl;
  logic         i_start;
  logic [W-1:0] o_c, o_hi, o_lo;
  logic         o_zero, o_overflow, o_busy, o_done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_ctrl     (i_ctrl),
    .i_start    (i_start),
    .o_c        (o_c),
    .o_zero     (o_zero),
    .o_overflow (o_overflow),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_hi       (o_hi),
    .o_lo       (o_lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic comb(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] ec, input logic ez, input logic eov);
    i_ctrl = op; i_a = a; i_b = b;
    #1;
    chk({tag, "_c"}, o_c, ec);
    chk({tag, "_zero"}, o_zero, ez);
    chk({tag, "_ov"}, o_overflow, eov);
  endtask

  // Issue start for one edge, then scramble operands to prove they were latched
  task automatic launch(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    i_ctrl = op; i_a = a; i_b = b; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_a = 32'h5A5A_1234; i_b = 32'hDEAD_BEEF; i_ctrl = 4'b0000;
  endtask

  // Wait (bounded) for done; optionally pulse a competing start at cycle 'poke'
  task automatic wait_check(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el, input int poke);
    int n = 1;
    int nb = 0;
    while (!o_done && n < 100) begin
      if (o_busy) nb++;
      if (poke != 0 && n == poke) begin
        i_ctrl = 4'b1111; i_a = 100; i_b = 3; i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    i_start = 1'b0;
    chk({tag, "_lat"}, n, 33);
    chk({tag, "_busycyc"}, nb, 32);
    chk({tag, "_busy_at_done"}, o_busy, 1'b0);
    chk({tag, "_hi"}, o_hi, eh);
    chk({tag, "_lo"}, o_lo, el);
  endtask

  initial begin
    int seen;
    rst = 1'b1; i_start = 1'b0; i_ctrl = 4'b0000; i_a = '0; i_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_hi", o_hi, 32'h0);
    chk("rst_lo", o_lo, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Combinational operations
    comb("add_ov", 4'b0001, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
    comb("add", 4'b0001, 32'd10, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b0);
    comb("sub_z", 4'b0010, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
    comb("sub_ov", 4'b0010, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    comb("and", 4'b0011, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0);
    comb("or", 4'b0100, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 1'b0);
    comb("xor", 4'b0101, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0, 1'b0);
    comb("slt", 4'b0110, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0);
    comb("sltu", 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0);
    comb("sll", 4'b1000, 32'h24, 32'h1, 32'h10, 1'b0, 1'b0);
    comb("srl", 4'b1001, 32'h4, 32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0);
    comb("sra", 4'b1010, 32'h4, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0);
    comb("lui", 4'b1011, 32'h0, 32'h1234, 32'h1234_0000, 1'b0, 1'b0);
    comb("pass", 4'b0000, 32'h99, 32'hABCD, 32'hABCD, 1'b0, 1'b0);
    comb("mdu_c", 4'b1100, 32'h99, 32'h0, 32'h0, 1'b1, 1'b0);

    // Start with a non-MDU code is ignored
    @(negedge clk);
    i_ctrl = 4'b0001; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("nonmdu_busy", o_busy, 1'b0);

    // Multiply / divide results
    launch(4'b1100, 32'hFFFF_FFFD, 32'd7);
    wait_check("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    @(negedge clk);
    chk("mult_done_pulse", o_done, 1'b0);
    comb("hold", 4'b0001, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    chk("hold_hi", o_hi, 32'hFFFF_FFFF);

    launch(4'b1101, 32'hFFFF_FFFD, 32'd7);
    wait_check("multu", 32'h0000_0006, 32'hFFFF_FFEB, 0);
    launch(4'b1110, 32'hFFFF_FFF9, 32'd2);
    wait_check("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    launch(4'b1111, 32'd7, 32'd0);
    wait_check("divu0", 32'd7, 32'hFFFF_FFFF, 0);
    launch(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_check("divmin", 32'h0, 32'h8000_0000, 0);
    launch(4'b1110, 32'hFFFF_FFFB, 32'd0);
    wait_check("div0s", 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
    launch(4'b1111, 32'd100, 32'd3);
    wait_check("divu", 32'd1, 32'd33, 0);
    launch(4'b1100, 32'h8000_0000, 32'h8000_0000);
    wait_check("multmin", 32'h4000_0000, 32'h0, 0);

    // Start while busy is ignored; start in the done cycle chains a new op
    launch(4'b1100, 32'hFFFF_FFFD, 32'd7);
    wait_check("poke", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    launch(4'b1101, 32'hFFFF_FFFD, 32'd7);
    wait_check("chain", 32'h0000_0006, 32'hFFFF_FFEB, 0);
    @(negedge clk);
    chk("chain_idle", o_busy, 1'b0);

    // Reset in the middle of a divide abandons it
    launch(4'b1110, 32'hFFFF_FFF9, 32'd2);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstrun_busy", o_busy, 1'b0);
    chk("rstrun_hi", o_hi, 32'h0);
    chk("rstrun_lo", o_lo, 32'h0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_done) seen++;
      @(negedge clk);
    end
    chk("rstrun_nodone", seen, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
